// File: rtl/exception_unit.sv
// exception_unit: collects EX/M error flags, selects the oldest, squashes the
// pipeline and redirects fetch to the handler in the same cycle. It records the
// faulting PC and cause, returns on eret, and halts on a double fault.
module exception_unit #(
  parameter logic [15:0] HANDLER_ADDR = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,        // asynchronous, active-low
  input  logic [15:0] ex_pc,
  input  logic [15:0] m_pc,
  input  logic [2:0]  ex_err,       // bit0 overflow, bit1 div-by-zero, bit2 illegal
  input  logic        m_fault,
  input  logic        eret,
  output logic        force_flush,
  output logic        pc_override,
  output logic [15:0] pc_target,
  output logic [15:0] epc,
  output logic [3:0]  cause,
  output logic        in_handler,
  output logic        halted,
  output logic [7:0]  err_count
);

  localparam logic [3:0] CAUSE_OVF    = 4'h1;
  localparam logic [3:0] CAUSE_DIV0   = 4'h2;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'h3;
  localparam logic [3:0] CAUSE_MEM    = 4'h4;
  localparam logic [3:0] CAUSE_DOUBLE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HANDLER = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] epc_q, epc_d;
  logic [3:0]  cause_q, cause_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        err_valid;
  logic [3:0]  err_code;
  logic [15:0] err_pc;

  logic        flush_c;
  logic        override_c;
  logic [15:0] target_c;

  // Oldest-first error selection: M is older than EX; within EX illegal beats
  // div-by-zero beats overflow. Lower-priority errors are simply dropped.
  always_comb begin
    err_valid = 1'b0;
    err_code  = 4'h0;
    err_pc    = 16'h0000;
    if (m_fault) begin
      err_valid = 1'b1;
      err_code  = CAUSE_MEM;
      err_pc    = m_pc;
    end else if (ex_err[2]) begin
      err_valid = 1'b1;
      err_code  = CAUSE_ILLEGAL;
      err_pc    = ex_pc;
    end else if (ex_err[1]) begin
      err_valid = 1'b1;
      err_code  = CAUSE_DIV0;
      err_pc    = ex_pc;
    end else if (ex_err[0]) begin
      err_valid = 1'b1;
      err_code  = CAUSE_OVF;
      err_pc    = ex_pc;
    end
  end

  // Next-state and same-cycle redirect decode for the IDLE/HANDLER/HALT FSM.
  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    flush_c    = 1'b0;
    override_c = 1'b0;
    target_c   = 16'h0000;
    unique case (state_q)
      S_IDLE: begin
        // eret outside the handler has no effect
        if (err_valid) begin
          flush_c    = 1'b1;
          override_c = 1'b1;
          target_c   = HANDLER_ADDR;
          epc_d      = err_pc;
          cause_d    = err_code;
          cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          state_d    = S_HANDLER;
        end
      end
      S_HANDLER: begin
        // an error wins over a simultaneous eret and becomes a double fault
        if (err_valid) begin
          flush_c    = 1'b1;
          override_c = 1'b1;
          target_c   = HANDLER_ADDR;
          epc_d      = err_pc;
          cause_d    = CAUSE_DOUBLE;
          cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          state_d    = S_HALT;
        end else if (eret) begin
          flush_c    = 1'b1;
          override_c = 1'b1;
          target_c   = epc_q + 16'd2;   // wraps naturally at 16 bits
          state_d    = S_IDLE;
        end
      end
      S_HALT: begin
        // park fetch on the faulting PC until reset
        flush_c    = 1'b1;
        override_c = 1'b1;
        target_c   = epc_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and exception record registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      epc_q   <= 16'h0000;
      cause_q <= 4'h0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control outputs are held low for the whole time reset is asserted.
  always_comb begin
    force_flush = reset & flush_c;
    pc_override = reset & override_c;
    pc_target   = reset ? target_c : 16'h0000;
    in_handler  = reset & (state_q == S_HANDLER);
    halted      = reset & (state_q == S_HALT);
  end

  assign epc       = epc_q;
  assign cause     = cause_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: table-driven one-row-per-cycle vectors plus hand-written
// sequences for HALT hold, reset from HALT and err_count saturation.
module tb_exception_unit;

  logic        clk;
  logic        reset;
  logic [15:0] ex_pc;
  logic [15:0] m_pc;
  logic [2:0]  ex_err;
  logic        m_fault;
  logic        eret;
  logic        force_flush;
  logic        pc_override;
  logic [15:0] pc_target;
  logic [15:0] epc;
  logic [3:0]  cause;
  logic        in_handler;
  logic        halted;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  exception_unit #(.HANDLER_ADDR(16'h0100)) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_pc      (ex_pc),
    .m_pc       (m_pc),
    .ex_err     (ex_err),
    .m_fault    (m_fault),
    .eret       (eret),
    .force_flush(force_flush),
    .pc_override(pc_override),
    .pc_target  (pc_target),
    .epc        (epc),
    .cause      (cause),
    .in_handler (in_handler),
    .halted     (halted),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic [15:0] ex_pc;
    logic [15:0] m_pc;
    logic [2:0]  ex_err;
    logic        m_fault;
    logic        eret;
  } in_t;

  typedef struct packed {
    logic        ff;
    logic        po;
    logic [15:0] tgt;
    logic [15:0] epc;
    logic [3:0]  cause;
    logic        ih;
    logic        hl;
    logic [7:0]  cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [15:0] xpc, input logic [15:0] mpc,
                     input logic [2:0] xe, input logic mf, input logic er,
                     input logic ff, input logic po, input logic [15:0] tgt,
                     input logic [15:0] ep, input logic [3:0] ca, input logic ih,
                     input logic hl, input logic [7:0] cnt);
    vec_t v;
    v.i = '{rst_n: r, ex_pc: xpc, m_pc: mpc, ex_err: xe, m_fault: mf, eret: er};
    v.o = '{ff: ff, po: po, tgt: tgt, epc: ep, cause: ca, ih: ih, hl: hl, cnt: cnt};
    vecs.push_back(v);
  endtask

  // One cycle: drive on the falling edge, sample 1 ns later; registered outputs
  // reflect all rising edges before this cycle.
  task automatic step(input in_t iv, input out_t exp, input string name);
    out_t act;
    @(negedge clk);
    reset   = iv.rst_n;
    ex_pc   = iv.ex_pc;
    m_pc    = iv.m_pc;
    ex_err  = iv.ex_err;
    m_fault = iv.m_fault;
    eret    = iv.eret;
    #1;
    act = '{ff: force_flush, po: pc_override, tgt: pc_target, epc: epc, cause: cause,
            ih: in_handler, hl: halted, cnt: err_count};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ff=%b po=%b tgt=%h epc=%h cause=%h ih=%b hl=%b cnt=%h, want ff=%b po=%b tgt=%h epc=%h cause=%h ih=%b hl=%b cnt=%h",
               name, act.ff, act.po, act.tgt, act.epc, act.cause, act.ih, act.hl, act.cnt,
               exp.ff, exp.po, exp.tgt, exp.epc, exp.cause, exp.ih, exp.hl, exp.cnt);
    end else begin
      $display("ok   %s: ff=%b po=%b tgt=%h epc=%h cause=%h ih=%b hl=%b cnt=%h",
               name, act.ff, act.po, act.tgt, act.epc, act.cause, act.ih, act.hl, act.cnt);
    end
  endtask

  initial begin
    in_t  iv;
    out_t ov;

    reset = 1'b0; ex_pc = '0; m_pc = '0; ex_err = '0; m_fault = 1'b0; eret = 1'b0;

    //  rst  ex_pc    m_pc     err     mf    er  | ff po tgt      epc      cause ih hl cnt
    add(0, 16'h1234, 16'h5678, 3'b111, 1'b1, 1'b1, 0, 0, 16'h0000, 16'h0000, 4'h0, 0, 0, 8'd0); // in reset
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0000, 4'h0, 0, 0, 8'd0);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0000, 4'h0, 0, 0, 8'd0);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0000, 4'h0, 0, 0, 8'd0);
    // overflow in IDLE, handled, returned
    add(1, 16'h0040, 16'h0000, 3'b001, 1'b0, 1'b0, 1, 1, 16'h0100, 16'h0000, 4'h0, 0, 0, 8'd0);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0040, 4'h1, 1, 0, 8'd1);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 1, 1, 16'h0042, 16'h0040, 4'h1, 1, 0, 8'd1);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0040, 4'h1, 0, 0, 8'd1);
    // eret in IDLE ignored
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0040, 4'h1, 0, 0, 8'd1);
    // div0 beats overflow inside EX
    add(1, 16'h0050, 16'h0000, 3'b011, 1'b0, 1'b0, 1, 1, 16'h0100, 16'h0040, 4'h1, 0, 0, 8'd1);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0050, 4'h2, 1, 0, 8'd2);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 1, 1, 16'h0052, 16'h0050, 4'h2, 1, 0, 8'd2);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0050, 4'h2, 0, 0, 8'd2);
    // asynchronous reset clears the record
    add(0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0000, 4'h0, 0, 0, 8'd0);
    // memory fault beats EX errors
    add(1, 16'h0024, 16'h0022, 3'b110, 1'b1, 1'b0, 1, 1, 16'h0100, 16'h0000, 4'h0, 0, 0, 8'd0);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0022, 4'h4, 1, 0, 8'd1);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 1, 1, 16'h0024, 16'h0022, 4'h4, 1, 0, 8'd1);
    // illegal opcode at FFFE, eret wraps to 0000
    add(1, 16'hFFFE, 16'h0000, 3'b101, 1'b0, 1'b0, 1, 1, 16'h0100, 16'h0022, 4'h4, 0, 0, 8'd1);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'hFFFE, 4'h3, 1, 0, 8'd2);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 1, 1, 16'h0000, 16'hFFFE, 4'h3, 1, 0, 8'd2);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'hFFFE, 4'h3, 0, 0, 8'd2);
    // enter handler, then double fault with eret in the same cycle
    add(1, 16'h0200, 16'h0000, 3'b001, 1'b0, 1'b0, 1, 1, 16'h0100, 16'hFFFE, 4'h3, 0, 0, 8'd2);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0200, 4'h1, 1, 0, 8'd3);
    add(1, 16'h0104, 16'h0000, 3'b010, 1'b0, 1'b1, 1, 1, 16'h0100, 16'h0200, 4'h1, 1, 0, 8'd3);
    add(1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 1, 1, 16'h0104, 16'h0104, 4'hF, 0, 1, 8'd4);

    foreach (vecs[k]) step(vecs[k].i, vecs[k].o, $sformatf("vec%0d", k));

    // HALT holds for 12 cycles regardless of inputs
    for (int c = 0; c < 12; c++) begin
      iv = '{rst_n: 1'b1, ex_pc: 16'($urandom), m_pc: 16'($urandom),
             ex_err: 3'($urandom), m_fault: 1'($urandom), eret: 1'($urandom)};
      ov = '{ff: 1, po: 1, tgt: 16'h0104, epc: 16'h0104, cause: 4'hF, ih: 0, hl: 1, cnt: 8'd4};
      step(iv, ov, $sformatf("halt_hold%0d", c));
    end

    // reset from HALT: everything cleared immediately, stays in IDLE afterwards
    iv = '{rst_n: 1'b0, ex_pc: 16'h0104, m_pc: 16'h0000, ex_err: 3'b111, m_fault: 1'b1, eret: 1'b1};
    ov = '0;
    step(iv, ov, "halt_reset");
    iv = '{rst_n: 1'b1, ex_pc: 16'h0000, m_pc: 16'h0000, ex_err: 3'b000, m_fault: 1'b0, eret: 1'b0};
    step(iv, ov, "after_reset");

    // saturation: 300 error/eret pairs
    for (int p = 0; p < 300; p++) begin
      iv = '{rst_n: 1'b1, ex_pc: 16'(p * 2), m_pc: 16'h0000, ex_err: 3'b001, m_fault: 1'b0, eret: 1'b0};
      ov = '{ff: 1, po: 1, tgt: 16'h0100, epc: (p == 0) ? 16'h0000 : 16'((p - 1) * 2),
             cause: (p == 0) ? 4'h0 : 4'h1, ih: 0, hl: 0,
             cnt: (p > 255) ? 8'hFF : 8'(p)};
      if (p < 3 || (p >= 253 && p <= 257) || p == 299)
        step(iv, ov, $sformatf("sat_err%0d", p));
      else begin
        @(negedge clk);
        reset = iv.rst_n; ex_pc = iv.ex_pc; m_pc = iv.m_pc;
        ex_err = iv.ex_err; m_fault = iv.m_fault; eret = iv.eret;
      end
      @(negedge clk);
      ex_err = 3'b000; eret = 1'b1;
    end
    iv = '{rst_n: 1'b1, ex_pc: 16'h0000, m_pc: 16'h0000, ex_err: 3'b000, m_fault: 1'b0, eret: 1'b0};
    ov = '{ff: 0, po: 0, tgt: 16'h0000, epc: 16'd598, cause: 4'h1, ih: 0, hl: 0, cnt: 8'hFF};
    step(iv, ov, "sat_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, required completion");
    $fatal(1, "timeout");
  end

endmodule
